// File: rtl/timer_pkg.sv
// Shared encodings for bus_timer: FSM states, register offsets, CTRL fields, byte-merge helper.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

  localparam logic [1:0] AddrCtrl     = 2'd0;
  localparam logic [1:0] AddrPreset   = 2'd1;
  localparam logic [1:0] AddrCount    = 2'd2;
  localparam logic [1:0] AddrPrescale = 2'd3;

  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlModeLo = 1;
  localparam int unsigned CtrlModeHi = 2;
  localparam int unsigned CtrlIm     = 3;
  localparam int unsigned CtrlW      = 4;

  // Only 01 is periodic; 00 and the reserved 1x codes behave as one-shot.
  localparam logic [1:0] ModePeriodic = 2'b01;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Peripheral bus seen by bus_timer: bridge select, CPU write path, read data and interrupt.
interface bus_timer_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (output sel, addr, we, be, wd, input rd, irq);
  modport slave  (input sel, addr, we, be, wd, output rd, irq);
endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for bus_timer: one tick every div+1 enabled clocks; clr restarts the phase.
module timer_prescaler #(
  parameter int unsigned PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PSC_W-1:0] div,
  output logic             tick
);

  logic [PSC_W-1:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Programmable one-shot/periodic countdown timer on the peripheral bus.
// Define TIMER_PRESCALE_EN to add the PRESCALE register at 0xC and the tick prescaler.
module bus_timer
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  bus_timer_if.slave bus
);

  state_e           state_q;
  logic [CtrlW-1:0] ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             pending_q;
  logic [PSC_W-1:0] prescale_q;
  logic             tick;

  logic             wr_en;
  logic             ctrl_wr;
  logic             preset_wr;
  logic [CtrlW-1:0] ctrl_new;

  always_comb begin
    wr_en     = bus.sel & bus.we;
    ctrl_wr   = wr_en && (bus.addr == AddrCtrl);
    preset_wr = wr_en && (bus.addr == AddrPreset);
    // All CTRL fields live in byte 0.
    ctrl_new  = bus.be[0] ? bus.wd[CtrlW-1:0] : ctrl_q;
  end

`ifdef TIMER_PRESCALE_EN
  logic prescale_wr;
  assign prescale_wr = wr_en && (bus.addr == AddrPrescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
    end else if (prescale_wr) begin
      prescale_q <= PSC_W'(be_merge(32'(prescale_q), bus.wd, bus.be));
    end
  end

  timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q == StLoad) || ctrl_wr),
    .en    (state_q == StCnt),
    .div   (prescale_q),
    .tick  (tick)
  );
`else
  assign prescale_q = '0;
  assign tick       = 1'b1;
`endif

  // A CTRL write outranks every FSM action, including a terminal count in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (preset_wr) begin
        preset_q <= CNT_W'(be_merge(32'(preset_q), bus.wd, bus.be));
      end
      if (ctrl_wr) begin
        ctrl_q    <= ctrl_new;
        pending_q <= 1'b0;
        state_q   <= ctrl_new[CtrlEn] ? StLoad : StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ctrl_q[CtrlEn]) state_q <= StLoad;
          end
          StLoad: begin
            count_q   <= preset_q;
            pending_q <= 1'b0;
            state_q   <= StCnt;
          end
          StCnt: begin
            if (!ctrl_q[CtrlEn]) begin
              state_q <= StIdle;
            end else if (tick) begin
              if (count_q <= CNT_W'(1)) begin
                count_q <= '0;
                state_q <= StInt;
              end else begin
                count_q <= count_q - 1'b1;
              end
            end
          end
          StInt: begin
            pending_q <= 1'b1;
            if (ctrl_q[CtrlModeHi:CtrlModeLo] == ModePeriodic) begin
              state_q <= StLoad;
            end else begin
              ctrl_q[CtrlEn] <= 1'b0;
              state_q        <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      AddrCtrl:     bus.rd = 32'(ctrl_q);
      AddrPreset:   bus.rd = 32'(preset_q);
      AddrCount:    bus.rd = 32'(count_q);
      AddrPrescale: bus.rd = 32'(prescale_q);
      default:      bus.rd = '0;
    endcase
  end

  assign bus.irq = pending_q & ctrl_q[CtrlIm];

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: each bus step may queue an expected rd/irq pair,
// and a negedge monitor compares it against the DUT in that same cycle.
module tb_bus_timer;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_timer_if bus ();

  bus_timer #(
    .CNT_W (32),
    .PSC_W (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic chk_req = 1'b0;
  int   n_vec   = 0;
  int   n_fail  = 0;

  // One-shot PRESET=5: LOAD cycle, then 5..1, INT at 0, irq after the 7th edge.
  logic [31:0] t1_cnt[8] = '{0, 5, 4, 3, 2, 1, 0, 0};
  logic        t1_irq[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  // Periodic PRESET=3: period LOAD,3,2,1,INT; COUNT stays 0 through INT and LOAD.
  logic [31:0] t2_cnt[12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
  logic        t2_irq[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  // After collision: COUNT holds 1 in the restart LOAD, then 3,2,1,0 and irq.
  logic [31:0] t4_cnt[6] = '{1, 3, 2, 1, 0, 0};
  logic        t4_irq[6] = '{0, 0, 0, 0, 0, 1};
`ifdef TIMER_PRESCALE_EN
  logic [31:0] t6_cnt[9] = '{0, 2, 2, 2, 1, 1, 1, 0, 0};
  logic        t6_irq[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
`endif

  always @(negedge clk) begin
    if (chk_req) begin
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underrun: strobe with no expected entry, rd=%08h irq=%b",
                 bus.rd, bus.irq);
      end else begin
        cur = sb.pop_front();
        n_vec++;
        if (bus.rd !== cur.rd || bus.irq !== cur.irq) begin
          n_fail++;
          $display("FAIL %s: got rd=%08h irq=%b, want rd=%08h irq=%b",
                   cur.name, bus.rd, bus.irq, cur.rd, cur.irq);
        end
      end
    end
  end

  task automatic step(input logic sel_v, input logic we_v, input logic [1:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic chk,
                      input logic [31:0] exp_rd, input logic exp_irq, input string name);
    exp_t e;
    bus.sel  = sel_v;
    bus.we   = we_v;
    bus.addr = a;
    bus.wd   = d;
    bus.be   = b;
    if (chk) begin
      e.rd   = exp_rd;
      e.irq  = exp_irq;
      e.name = name;
      sb.push_back(e);
    end
    chk_req = chk;
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b1, 1'b1, a, d, b, 1'b0, '0, 1'b0, "");
  endtask

  task automatic rdc(input logic [1:0] a, input logic [31:0] exp_rd, input logic exp_irq,
                     input string name);
    step(1'b0, 1'b0, a, '0, 4'h0, 1'b1, exp_rd, exp_irq, name);
  endtask

  task automatic nop();
    step(1'b0, 1'b0, AddrCtrl, '0, 4'h0, 1'b0, '0, 1'b0, "");
  endtask

  initial begin
    reset    = 1'b0;
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = AddrCtrl;
    bus.wd   = '0;
    bus.be   = 4'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    rdc(AddrCtrl, 32'h0, 1'b0, "reset_ctrl");
    rdc(AddrPreset, 32'h0, 1'b0, "reset_preset");
    reset = 1'b1;
    rdc(AddrCount, 32'h0, 1'b0, "reset_count");

    // One-shot
    wr(AddrPreset, 32'd5, 4'hF);
    wr(AddrCtrl, 32'h9, 4'hF);
    for (int i = 0; i < 8; i++) rdc(AddrCount, t1_cnt[i], t1_irq[i], $sformatf("oneshot_c%0d", i + 1));
    rdc(AddrCtrl, 32'h8, 1'b1, "oneshot_en_cleared");
    step(1'b1, 1'b1, AddrCtrl, 32'h0, 4'hF, 1'b1, 32'h8, 1'b1, "oneshot_irq_held");
    rdc(AddrCtrl, 32'h0, 1'b0, "oneshot_irq_drop");

    // Periodic
    wr(AddrPreset, 32'd3, 4'hF);
    wr(AddrCtrl, 32'hB, 4'hF);
    for (int i = 0; i < 12; i++) rdc(AddrCount, t2_cnt[i], t2_irq[i], $sformatf("periodic_c%0d", i + 1));
    wr(AddrCtrl, 32'h0, 4'hF);
    nop();
    rdc(AddrCount, 32'd2, 1'b0, "disable_holds_count");

    // Byte enables, read-only COUNT, sel=0, CTRL upper bits
    wr(AddrPreset, 32'hAABBCCDD, 4'b0101);
    rdc(AddrPreset, 32'h00BB00DD, 1'b0, "be_preset");
    wr(AddrCount, 32'h1234, 4'hF);
    rdc(AddrCount, 32'd2, 1'b0, "count_read_only");
    step(1'b0, 1'b1, AddrPreset, 32'hFFFFFFFF, 4'hF, 1'b0, '0, 1'b0, "");
    rdc(AddrPreset, 32'h00BB00DD, 1'b0, "sel0_ignored");
    wr(AddrCtrl, 32'hFFFFFFF6, 4'hF);
    rdc(AddrCtrl, 32'h6, 1'b0, "ctrl_upper_zero");

    // Collision: CTRL write lands on the 1->0 edge
    wr(AddrPreset, 32'd3, 4'hF);
    wr(AddrCtrl, 32'h9, 4'hF);
    rdc(AddrCount, 32'd2, 1'b0, "coll_load");
    rdc(AddrCount, 32'd3, 1'b0, "coll_c3");
    rdc(AddrCount, 32'd2, 1'b0, "coll_c2");
    step(1'b1, 1'b1, AddrCtrl, 32'h9, 4'hF, 1'b1, 32'h9, 1'b0, "coll_write");
    for (int i = 0; i < 6; i++) rdc(AddrCount, t4_cnt[i], t4_irq[i], $sformatf("coll_after%0d", i + 1));
    wr(AddrCtrl, 32'h0, 4'hF);

    // Reset mid-count
    wr(AddrPreset, 32'h50, 4'hF);
    wr(AddrCtrl, 32'h9, 4'hF);
    repeat (17) nop();
    rdc(AddrCount, 32'h40, 1'b0, "pre_reset_count");
    reset = 1'b0;
    rdc(AddrCount, 32'h0, 1'b0, "rst_async_count");
    rdc(AddrCtrl, 32'h0, 1'b0, "rst_ctrl");
    rdc(AddrPreset, 32'h0, 1'b0, "rst_preset");
    rdc(AddrPrescale, 32'h0, 1'b0, "rst_prescale");
    reset = 1'b1;
    wr(AddrPreset, 32'd7, 4'hF);
    repeat (3) nop();
    rdc(AddrCount, 32'h0, 1'b0, "post_rst_idle");

    // Prescaler register
`ifdef TIMER_PRESCALE_EN
    wr(AddrPrescale, 32'd2, 4'hF);
    rdc(AddrPrescale, 32'd2, 1'b0, "prescale_rb");
    wr(AddrPreset, 32'd2, 4'hF);
    wr(AddrCtrl, 32'h9, 4'hF);
    for (int i = 0; i < 9; i++) rdc(AddrCount, t6_cnt[i], t6_irq[i], $sformatf("psc_c%0d", i + 1));
`else
    wr(AddrPrescale, 32'd2, 4'hF);
    rdc(AddrPrescale, 32'h0, 1'b0, "prescale_absent");
`endif

    nop();
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
